wb_write_arbiter: RTL and testbench

//  Writer-side front end of the register file's single write port. Merges the non-stallable
//  MEM/WB pipeline write with results from long-latency units (mul/div) over a valid/ready channel.

---
 rtl/wb_write_arbiter_pkg.sv | 6 +
 rtl/wb_fifo.sv | 63 ++++++
 rtl/wb_write_arbiter.sv | 71 +++++++
 tb/tb_wb_write_arbiter.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_write_arbiter_pkg.sv
// wb_write_arbiter_pkg: shared sizes for the register-file write-port arbiter and its FIFO
package wb_write_arbiter_pkg;
  localparam int WB_FIFO_DEPTH = 4;
  localparam int REG_AW = 5;
  localparam int REG_DW = 32;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: DEPTH x {valid, addr, data} queue with push/pop, count and address-match invalidate
//   push/push_addr/push_data : store a new valid entry at the write pointer
//   pop                      : retire the head entry
//   inv/inv_addr             : clear the valid bit of every stored entry whose address matches
//   head_*                   : fields of the entry at the read pointer
//   count, valid, addrs      : occupancy and per-entry state for busy lookups
module wb_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  parameter int AW = REG_AW,
  parameter int DW = REG_DW,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [AW-1:0]          push_addr,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  input  logic                   inv,
  input  logic [AW-1:0]          inv_addr,
  output logic                   head_valid,
  output logic [AW-1:0]          head_addr,
  output logic [DW-1:0]          head_data,
  output logic [CW-1:0]          count,
  output logic [DEPTH-1:0]       valid,
  output logic [DEPTH-1:0][AW-1:0] addrs
);
  logic [PW-1:0] rd, wr;
  logic [DEPTH-1:0][DW-1:0] data;
  logic [DEPTH-1:0] inv_vec, valid_n;
  // Invalidate hits only already-stored entries; a same-cycle push overrides its own slot as valid.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) inv_vec[i] = inv && addrs[i] == inv_addr;
    valid_n = valid & ~inv_vec;
    if (pop) valid_n[rd] = 1'b0;
    if (push) valid_n[wr] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      valid <= '0;
    end else begin
      rd <= rd + PW'(pop);
      wr <= wr + PW'(push);
      count <= count + CW'(push) - CW'(pop);
      valid <= valid_n;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addrs[wr] <= push_addr;
      data[wr] <= push_data;
    end
  end
  assign head_valid = valid[rd];
  assign head_addr = addrs[rd];
  assign head_data = data[rd];
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges MEM/WB writes with queued long-latency results onto one RF write port
//   pipe_we/pipe_waddr/pipe_wdata : non-stallable pipeline write, always owns the port
//   lu_valid/lu_waddr/lu_wdata/lu_ready : long-latency result channel into the FIFO
//   rf_we/rf_waddr/rf_wdata       : combinational register file write port
//   q1_addr/q1_busy, q2_addr/q2_busy : decode lookups for registers with pending queued writes
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  parameter int AW = REG_AW,
  parameter int DW = REG_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_waddr,
  input  logic [DW-1:0] pipe_wdata,
  input  logic          lu_valid,
  input  logic [AW-1:0] lu_waddr,
  input  logic [DW-1:0] lu_wdata,
  output logic          lu_ready,
  output logic          rf_we,
  output logic [AW-1:0] rf_waddr,
  output logic [DW-1:0] rf_wdata,
  input  logic [AW-1:0] q1_addr,
  output logic          q1_busy,
  input  logic [AW-1:0] q2_addr,
  output logic          q2_busy
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic slot, push, pop, head_valid, hit1, hit2;
  logic [AW-1:0] head_addr;
  logic [DW-1:0] head_data;
  logic [CW-1:0] count;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0][AW-1:0] addrs;
  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .push_addr(lu_waddr),
    .push_data(lu_wdata),
    .pop(pop),
    .inv(slot),
    .inv_addr(pipe_waddr),
    .head_valid(head_valid),
    .head_addr(head_addr),
    .head_data(head_data),
    .count(count),
    .valid(valid),
    .addrs(addrs)
  );
  // Outputs are gated by rst because the FIFO state only clears at the end of the reset cycle.
  always_comb begin
    slot = pipe_we && pipe_waddr != '0;
    lu_ready = !rst && count < CW'(DEPTH);
    push = lu_valid && lu_ready && lu_waddr != '0;
    pop = !rst && !slot && count != '0;
    rf_we = rst ? 1'b0 : slot ? 1'b1 : pop && head_valid;
    rf_waddr = rst ? '0 : slot ? pipe_waddr : pop ? head_addr : '0;
    rf_wdata = rst ? '0 : slot ? pipe_wdata : pop ? head_data : '0;
    hit1 = push && lu_waddr == q1_addr;
    hit2 = push && lu_waddr == q2_addr;
    for (int i = 0; i < DEPTH; i++) begin
      hit1 = hit1 || (valid[i] && addrs[i] == q1_addr);
      hit2 = hit2 || (valid[i] && addrs[i] == q2_addr);
    end
    q1_busy = !rst && q1_addr != '0 && hit1;
    q2_busy = !rst && q2_addr != '0 && hit2;
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed scenarios plus randomized traffic against a queue-based model
module tb_wb_write_arbiter;
  localparam int DEPTH = 4;
  localparam int AW = 5;
  localparam int DW = 32;
  logic clk = 0, rst = 1, pipe_we = 0, lu_valid = 0;
  logic [AW-1:0] pipe_waddr = '0, lu_waddr = '0, q1_addr = '0, q2_addr = '0, rf_waddr;
  logic [DW-1:0] pipe_wdata = '0, lu_wdata = '0, rf_wdata;
  logic lu_ready, rf_we, q1_busy, q2_busy;
  int checks = 0, errors = 0;
  typedef struct {
    logic v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;
  ent_t mq[$];
  logic e_ready, e_we, e_b1, e_b2;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_data;

  wb_write_arbiter dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .q1_addr(q1_addr), .q1_busy(q1_busy), .q2_addr(q2_addr), .q2_busy(q2_busy)
  );

  always #5 clk = ~clk;

  function automatic logic m_busy(input logic [AW-1:0] a);
    if (rst || a == 0) return 1'b0;
    if (lu_valid && mq.size() < DEPTH && lu_waddr == a) return 1'b1;
    foreach (mq[i]) if (mq[i].v && mq[i].a == a) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_outputs();
    bit slot = pipe_we && pipe_waddr != 0;
    bit pop = !slot && mq.size() > 0;
    e_ready = !rst && mq.size() < DEPTH;
    e_we = rst ? 1'b0 : slot ? 1'b1 : pop ? mq[0].v : 1'b0;
    e_addr = rst ? '0 : slot ? pipe_waddr : pop ? mq[0].a : '0;
    e_data = rst ? '0 : slot ? pipe_wdata : pop ? mq[0].d : '0;
    e_b1 = m_busy(q1_addr);
    e_b2 = m_busy(q2_addr);
  endfunction

  task automatic tick();
    bit slot = pipe_we && pipe_waddr != 0;
    bit push = !rst && lu_valid && mq.size() < DEPTH && lu_waddr != 0;
    bit pop = !rst && !slot && mq.size() > 0;
    bit r = rst;
    logic [AW-1:0] pa = pipe_waddr;
    ent_t e = '{1'b1, lu_waddr, lu_wdata};
    @(posedge clk);
    if (r) mq.delete();
    else begin
      if (slot) foreach (mq[i]) if (mq[i].a == pa) mq[i].v = 1'b0;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(e);
    end
    #1;
  endtask

  task automatic drive(input logic pw, input logic [AW-1:0] pa, input logic [DW-1:0] pd,
                       input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    pipe_we = pw; pipe_waddr = pa; pipe_wdata = pd;
    lu_valid = lv; lu_waddr = la; lu_wdata = ld;
  endtask

  task automatic test_reset();
    rst = 1;
    drive(1, 5'd3, 32'h1234, 1, 5'd4, 32'h5678);
    q1_addr = 5'd4; q2_addr = 5'd3;
    @(negedge clk);
    checks += 4;
    if (lu_ready !== 1'b0) begin errors++; $display("FAIL reset lu_ready got %b exp 0", lu_ready); end
    if (rf_we !== 1'b0) begin errors++; $display("FAIL reset rf_we got %b exp 0", rf_we); end
    if ({rf_waddr, rf_wdata} !== '0) begin errors++; $display("FAIL reset rf_addr_data got %h/%h exp 0/0", rf_waddr, rf_wdata); end
    if ({q1_busy, q2_busy} !== 2'b00) begin errors++; $display("FAIL reset busy got %b%b exp 00", q1_busy, q2_busy); end
    tick();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks += 2;
    if (lu_ready !== 1'b1) begin errors++; $display("FAIL post_reset lu_ready got %b exp 1", lu_ready); end
    if (rf_we !== 1'b0) begin errors++; $display("FAIL post_reset rf_we got %b exp 0", rf_we); end
    tick();
  endtask

  task automatic test_reset_mid_queue();
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'd3, 32'h33, 1, 5'(20 + i), 32'(i));
      tick();
    end
    rst = 1;
    drive(0, 0, 0, 1, 5'd23, 32'h77);
    q1_addr = 5'd20; q2_addr = 5'd21;
    @(negedge clk);
    checks += 3;
    if (lu_ready !== 1'b0) begin errors++; $display("FAIL midq_rst lu_ready got %b exp 0", lu_ready); end
    if (rf_we !== 1'b0) begin errors++; $display("FAIL midq_rst rf_we got %b exp 0", rf_we); end
    if ({q1_busy, q2_busy} !== 2'b00) begin errors++; $display("FAIL midq_rst busy got %b%b exp 00", q1_busy, q2_busy); end
    tick();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks += 3;
    if (rf_we !== 1'b0 || rf_waddr !== 5'd0) begin errors++; $display("FAIL midq_after rf got we=%b addr=%0d exp 0/0", rf_we, rf_waddr); end
    if ({q1_busy, q2_busy} !== 2'b00) begin errors++; $display("FAIL midq_after busy got %b%b exp 00", q1_busy, q2_busy); end
    if (lu_ready !== 1'b1) begin errors++; $display("FAIL midq_after lu_ready got %b exp 1", lu_ready); end
    tick();
  endtask

  task automatic test_idle_drain();
    drive(0, 0, 0, 1, 5'd5, 32'h11111111);
    q1_addr = 5'd5;
    @(negedge clk);
    checks += 2;
    if (q1_busy !== 1'b1) begin errors++; $display("FAIL drain_push q1_busy got %b exp 1", q1_busy); end
    if (rf_we !== 1'b0) begin errors++; $display("FAIL drain_push rf_we got %b exp 0", rf_we); end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks += 2;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 32'h11111111}) begin errors++; $display("FAIL drain_pop rf got %b/%0d/%h exp 1/5/11111111", rf_we, rf_waddr, rf_wdata); end
    if (q1_busy !== 1'b1) begin errors++; $display("FAIL drain_pop q1_busy got %b exp 1", q1_busy); end
    tick();
    @(negedge clk);
    checks += 2;
    if (q1_busy !== 1'b0) begin errors++; $display("FAIL drain_done q1_busy got %b exp 0", q1_busy); end
    if (rf_we !== 1'b0) begin errors++; $display("FAIL drain_done rf_we got %b exp 0", rf_we); end
    tick();
  endtask

  task automatic test_priority();
    drive(1, 5'd3, 32'h3, 1, 5'd7, 32'h77);
    q2_addr = 5'd7;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks += 2;
      if (rf_waddr !== 5'd3 || rf_we !== 1'b1) begin errors++; $display("FAIL prio_hold cyc %0d rf got %b/%0d exp 1/3", i, rf_we, rf_waddr); end
      if (q2_busy !== 1'b1) begin errors++; $display("FAIL prio_hold cyc %0d q2_busy got %b exp 1", i, q2_busy); end
      tick();
      lu_valid = 0;
    end
    pipe_we = 0;
    @(negedge clk);
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h77}) begin errors++; $display("FAIL prio_release rf got %b/%0d/%h exp 1/7/77", rf_we, rf_waddr, rf_wdata); end
    tick();
  endtask

  task automatic test_full();
    for (int i = 0; i < 5; i++) begin
      drive(1, 5'd3, 32'h3, 1, 5'(10 + i), 32'(100 + i));
      @(negedge clk);
      checks++;
      if (lu_ready !== (i < 4)) begin errors++; $display("FAIL full_fill attempt %0d lu_ready got %b exp %b", i, lu_ready, i < 4); end
      tick();
    end
    pipe_we = 0;
    @(negedge clk);
    checks += 2;
    if (lu_ready !== 1'b0) begin errors++; $display("FAIL full_pop lu_ready got %b exp 0", lu_ready); end
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd10, 32'd100}) begin errors++; $display("FAIL full_pop rf got %b/%0d/%0d exp 1/10/100", rf_we, rf_waddr, rf_wdata); end
    tick();
    lu_valid = 0;
    @(negedge clk);
    checks++;
    if (lu_ready !== 1'b1) begin errors++; $display("FAIL full_after lu_ready got %b exp 1", lu_ready); end
    repeat (4) tick();
  endtask

  task automatic test_invalidate();
    drive(1, 5'd4, 32'h4, 1, 5'd9, 32'hAAAA);
    q1_addr = 5'd9;
    tick();
    drive(1, 5'd9, 32'hBBBB, 0, 0, 0);
    @(negedge clk);
    checks += 2;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 5'd9, 32'hBBBB}) begin errors++; $display("FAIL inv_pipe rf got %b/%0d/%h exp 1/9/BBBB", rf_we, rf_waddr, rf_wdata); end
    if (q1_busy !== 1'b1) begin errors++; $display("FAIL inv_pipe q1_busy got %b exp 1", q1_busy); end
    tick();
    pipe_we = 0;
    @(negedge clk);
    checks += 2;
    if (rf_we !== 1'b0) begin errors++; $display("FAIL inv_pop rf_we got %b exp 0", rf_we); end
    if (q1_busy !== 1'b0) begin errors++; $display("FAIL inv_pop q1_busy got %b exp 0", q1_busy); end
    tick();
  endtask

  task automatic test_r0_filter();
    drive(0, 0, 0, 1, 5'd0, 32'hDEAD);
    q1_addr = 5'd0;
    @(negedge clk);
    checks += 2;
    if (q1_busy !== 1'b0) begin errors++; $display("FAIL r0_push q1_busy got %b exp 0", q1_busy); end
    if (lu_ready !== 1'b1) begin errors++; $display("FAIL r0_push lu_ready got %b exp 1", lu_ready); end
    tick();
    lu_valid = 0;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || rf_wdata !== '0) begin errors++; $display("FAIL r0_next rf got %b/%h exp 0/0", rf_we, rf_wdata); end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
      q1_addr = 5'($urandom_range(0, 7));
      q2_addr = 5'($urandom_range(0, 7));
      @(negedge clk);
      model_outputs();
      checks += 6;
      if (lu_ready !== e_ready) begin errors++; $display("FAIL rnd_lu_ready cyc %0d got %b exp %b", c, lu_ready, e_ready); end
      if (rf_we !== e_we) begin errors++; $display("FAIL rnd_rf_we cyc %0d got %b exp %b", c, rf_we, e_we); end
      if (rf_waddr !== e_addr) begin errors++; $display("FAIL rnd_rf_waddr cyc %0d got %0d exp %0d", c, rf_waddr, e_addr); end
      if (rf_wdata !== e_data) begin errors++; $display("FAIL rnd_rf_wdata cyc %0d got %h exp %h", c, rf_wdata, e_data); end
      if (q1_busy !== e_b1) begin errors++; $display("FAIL rnd_q1_busy cyc %0d addr %0d got %b exp %b", c, q1_addr, q1_busy, e_b1); end
      if (q2_busy !== e_b2) begin errors++; $display("FAIL rnd_q2_busy cyc %0d addr %0d got %b exp %b", c, q2_addr, q2_busy, e_b2); end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    #1;
    test_reset();
    test_reset_mid_queue();
    test_idle_drain();
    test_priority();
    test_full();
    test_invalidate();
    test_r0_filter();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
